// File: rtl/lstm_pkg.sv
// Shared definitions for the LSTM parameter/X feeder.
// FSM states, param_type codes and default load sizes.
package lstm_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD_W,
      ST_GAP_W,
      ST_LOAD_B,
      ST_GAP_B,
      ST_LOAD_C,
      ST_GAP_C,
      ST_RUN
   } state_t;

   localparam logic [2:0] SYSCALL_W       = 3'd0;
   localparam logic [2:0] SYSCALL_B       = 3'd1;
   localparam logic [2:0] SYSCALL_CONTEXT = 3'd2;
   localparam logic [2:0] IDLE            = 3'd7;

   localparam int DEF_W_SIZE       = 512;
   localparam int DEF_B_SIZE       = 32;
   localparam int DEF_CONTEXT_SIZE = 16;
   localparam int DEF_X_SIZE       = 8;
   localparam int DEF_GAP_CYCLES   = 4;

   function automatic logic [2:0] param_code(state_t s);
      unique case (s)
         ST_LOAD_W: return SYSCALL_W;
         ST_LOAD_B: return SYSCALL_B;
         ST_LOAD_C: return SYSCALL_CONTEXT;
         default:   return IDLE;
      endcase
   endfunction

endpackage

// File: rtl/lstm_x_assembler.sv
// Collects X_SIZE bytes into one X_t vector, first byte in the MSBs.
// Cleared by the parent when the vector is issued to the core.
module lstm_x_assembler
   import lstm_pkg::*;
#(
   parameter int X_SIZE = DEF_X_SIZE
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_push,
   input  logic [7:0]            i_data,
   input  logic                  i_clear,
   output logic [X_SIZE*8-1:0]   o_buf,
   output logic                  o_full
);

   localparam int XW = X_SIZE * 8;
   localparam int CW = $clog2(X_SIZE + 1);

   logic [XW-1:0] r_buf;
   logic [CW-1:0] r_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_buf <= '0;
         r_cnt <= '0;
      end else if (i_clear) begin
         r_cnt <= '0;
      end else if (i_push) begin
         r_buf <= (r_buf << 8) | XW'(i_data);
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign o_buf  = r_buf;
   assign o_full = (r_cnt == CW'(X_SIZE));

endmodule

// File: rtl/lstm_feeder.sv
// Streams W/B/context parameters into an LSTM core, then feeds X_t vectors.
// Optional load checksum on param_chksum: define LSTM_FEEDER_CHKSUM_EN.
module lstm_feeder
   import lstm_pkg::*;
#(
   parameter int W_SIZE       = DEF_W_SIZE,
   parameter int B_SIZE       = DEF_B_SIZE,
   parameter int CONTEXT_SIZE = DEF_CONTEXT_SIZE,
   parameter int X_SIZE       = DEF_X_SIZE,
   parameter int GAP_CYCLES   = DEF_GAP_CYCLES
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic                src_valid,
   input  logic [7:0]          src_data,
   output logic                src_ready,
   output logic                lstm_init,
   output logic [2:0]          param_type,
   output logic [7:0]          lstm_param,
   output logic                lstm_enable,
   output logic [X_SIZE*8-1:0] syscall_X_data,
   input  logic                lstm_done,
   output logic                busy,
   output logic                load_done,
   output logic [15:0]         x_count,
   output logic [7:0]          param_chksum
);

   localparam logic [15:0] W_LAST   = 16'(W_SIZE - 1);
   localparam logic [15:0] B_LAST   = 16'(B_SIZE - 1);
   localparam logic [15:0] C_LAST   = 16'(CONTEXT_SIZE - 1);
   localparam logic [15:0] GAP_LAST = 16'(GAP_CYCLES - 1);

   state_t r_state, w_nxt;
   logic [15:0] r_cnt;

   logic w_src_rdy, w_acc, w_load, w_gap, w_gap_last;
   logic w_x_push, w_x_full, w_issue;
   logic [X_SIZE*8-1:0] w_x_buf;

   logic                r_init;
   logic [7:0]          r_param;
   logic [2:0]          r_ptype;
   logic                r_enable;
   logic [X_SIZE*8-1:0] r_xdata;
   logic [15:0]         r_xcount;
   logic                r_armed;
   logic                r_load_done;

   assign w_load = (r_state == ST_LOAD_W) || (r_state == ST_LOAD_B)
                || (r_state == ST_LOAD_C);
   assign w_gap  = (r_state == ST_GAP_W) || (r_state == ST_GAP_B)
                || (r_state == ST_GAP_C);
   assign w_gap_last = (r_cnt == GAP_LAST);
   assign w_acc      = w_src_rdy & src_valid;
   assign w_x_push   = (r_state == ST_RUN) & w_acc;
   assign w_issue    = (r_state == ST_RUN) & w_x_full & lstm_done & r_armed;

   always_comb begin
      w_nxt     = r_state;
      w_src_rdy = 1'b0;
      unique case (r_state)
         ST_IDLE:   if (start) w_nxt = ST_LOAD_W;
         ST_LOAD_W: begin
            w_src_rdy = 1'b1;
            if (src_valid && r_cnt == W_LAST) w_nxt = ST_GAP_W;
         end
         ST_GAP_W:  if (w_gap_last) w_nxt = ST_LOAD_B;
         ST_LOAD_B: begin
            w_src_rdy = 1'b1;
            if (src_valid && r_cnt == B_LAST) w_nxt = ST_GAP_B;
         end
         ST_GAP_B:  if (w_gap_last) w_nxt = ST_LOAD_C;
         ST_LOAD_C: begin
            w_src_rdy = 1'b1;
            if (src_valid && r_cnt == C_LAST) w_nxt = ST_GAP_C;
         end
         ST_GAP_C:  if (w_gap_last) w_nxt = ST_RUN;
         ST_RUN:    w_src_rdy = ~w_x_full;
         default:   w_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_nxt;
         if (w_nxt != r_state)
            r_cnt <= '0;
         else if ((w_load && w_acc) || w_gap)
            r_cnt <= r_cnt + 16'd1;
      end
   end

   // param_type is registered with the byte so it tags the same cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_init      <= 1'b0;
         r_param     <= '0;
         r_ptype     <= IDLE;
         r_enable    <= 1'b0;
         r_xdata     <= '0;
         r_xcount    <= '0;
         r_armed     <= 1'b0;
         r_load_done <= 1'b0;
      end else begin
         r_init   <= w_load & w_acc;
         r_ptype  <= param_code(r_state);
         r_enable <= w_issue;
         if (w_load && w_acc)
            r_param <= src_data;
         if (w_issue) begin
            r_xdata <= w_x_buf;
            if (r_xcount != 16'hFFFF)
               r_xcount <= r_xcount + 16'd1;
         end
         if (r_state == ST_GAP_C && w_nxt == ST_RUN) begin
            r_armed     <= 1'b1;
            r_load_done <= 1'b1;
         end else if (r_state == ST_RUN) begin
            if (w_issue)
               r_armed <= 1'b0;
            else if (!lstm_done)
               r_armed <= 1'b1;
         end
      end
   end

   lstm_x_assembler #(.X_SIZE(X_SIZE)) u_xasm (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_x_push),
      .i_data  (src_data),
      .i_clear (w_issue),
      .o_buf   (w_x_buf),
      .o_full  (w_x_full)
   );

`ifdef LSTM_FEEDER_CHKSUM_EN
   logic [7:0] r_chk;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_chk <= '0;
      else if (r_state == ST_IDLE && start)
         r_chk <= '0;
      else if (w_load && w_acc)
         r_chk <= r_chk ^ src_data;
   end

   assign param_chksum = r_chk;
`else
   assign param_chksum = 8'h00;
`endif

   assign src_ready      = w_src_rdy;
   assign lstm_init      = r_init;
   assign param_type     = r_ptype;
   assign lstm_param     = r_param;
   assign lstm_enable    = r_enable;
   assign syscall_X_data = r_xdata;
   assign busy           = (r_state != ST_IDLE);
   assign load_done      = r_load_done;
   assign x_count        = r_xcount;

endmodule

// File: tb/tb_lstm_feeder.sv
// Directed bench for lstm_feeder: load/stall, RUN handshake, resets.
// Checksum expectations follow LSTM_FEEDER_CHKSUM_EN when defined.
module tb_lstm_feeder;

   logic        clk = 1'b0;
   logic        rst, start, src_valid, lstm_done;
   logic [7:0]  src_data;
   logic        src_ready, lstm_init, lstm_enable, busy, load_done;
   logic [2:0]  param_type;
   logic [7:0]  lstm_param, param_chksum;
   logic [63:0] syscall_X_data;
   logic [15:0] x_count;

   lstm_feeder dut (
      .clk            (clk),
      .rst            (rst),
      .start          (start),
      .src_valid      (src_valid),
      .src_data       (src_data),
      .src_ready      (src_ready),
      .lstm_init      (lstm_init),
      .param_type     (param_type),
      .lstm_param     (lstm_param),
      .lstm_enable    (lstm_enable),
      .syscall_X_data (syscall_X_data),
      .lstm_done      (lstm_done),
      .busy           (busy),
      .load_done      (load_done),
      .x_count        (x_count),
      .param_chksum   (param_chksum)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;
   int n_to     = 0;

`ifdef LSTM_FEEDER_CHKSUM_EN
   localparam logic [7:0] CHK_ONE_5A = 8'h5A;
`else
   localparam logic [7:0] CHK_ONE_5A = 8'h00;
`endif

   task automatic check(input string tag, input logic [63:0] obs,
                        input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   // Monitor: counts init-high cycles per param_type, low-run lengths,
   // byte ordering on lstm_param, and lstm_enable pulses.
   bit          mon_clr = 1'b0;
   bit          pat5a   = 1'b0;
   int          n_t [8];
   int          lowrun, idx, perr, n_en;
   int          gaps[$];
   int          stalls[$];
   logic [2:0]  last_t;
   bit          seen;

   initial n_en = 0;

   always @(negedge clk) begin
      if (lstm_enable) n_en++;
      if (mon_clr) begin
         foreach (n_t[k]) n_t[k] = 0;
         lowrun = 0; idx = 0; perr = 0; seen = 0;
         gaps.delete(); stalls.delete();
      end else if (lstm_init) begin
         if (seen && lowrun > 0) begin
            if (param_type != last_t) gaps.push_back(lowrun);
            else stalls.push_back(lowrun);
         end
         n_t[param_type]++;
         if (lstm_param !== (pat5a ? 8'h5A : idx[7:0])) perr++;
         idx++;
         last_t = param_type;
         seen   = 1'b1;
         lowrun = 0;
      end else if (seen) begin
         lowrun++;
      end
   end

   task automatic mon_clear();
      mon_clr = 1'b1;
      @(negedge clk);
      #1 mon_clr = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b);
      bit ok;
      ok = 1'b0;
      src_data  = b;
      src_valid = 1'b1;
      for (int k = 0; k < 200; k++) begin
         @(negedge clk);
         if (src_ready) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) n_to++;
      @(posedge clk);
      #1 src_valid = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   task automatic wait_load_done();
      for (int k = 0; k < 200; k++) begin
         @(negedge clk);
         if (load_done) break;
      end
   endtask

   task automatic wait_en(input int target);
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (n_en >= target) break;
      end
      repeat (3) @(negedge clk);
      @(posedge clk);
      #1;
   endtask

   function automatic int qget(input int q[$], input int i);
      return (q.size() > i) ? q[i] : -1;
   endfunction

   int rdy_hi;

   initial begin
      rst = 1'b1; start = 1'b0; src_valid = 1'b0;
      src_data = 8'h00; lstm_done = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", busy, 0);
      check("rst_ptype", param_type, 7);
      check("rst_ready", src_ready, 0);
      check("rst_init", lstm_init, 0);
      check("rst_enable", lstm_enable, 0);
      check("rst_load_done", load_done, 0);
      check("rst_xcount", x_count, 0);
      check("rst_xdata", syscall_X_data, 0);
      check("rst_chksum", param_chksum, 0);
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("idle_no_start", busy, 0);

      mon_clear();
      @(posedge clk);
      #1 pulse_start();
      check("load_busy", busy, 1);
      for (int i = 0; i < 560; i++) begin
         if (i == 200) begin
            repeat (3) @(posedge clk);
            #1;
         end
         send_byte(i[7:0]);
      end
      wait_load_done();
      check("load_done", load_done, 1);
      check("n_w", n_t[0], 512);
      check("n_b", n_t[1], 32);
      check("n_c", n_t[2], 16);
      check("n_other", n_t[7], 0);
      check("n_gaps", gaps.size(), 2);
      check("gap0", qget(gaps, 0), 4);
      check("gap1", qget(gaps, 1), 4);
      check("n_stalls", stalls.size(), 1);
      check("stall_len", qget(stalls, 0), 3);
      check("param_order", perr, 0);
      check("load_chksum", param_chksum, 0);
      check("load_timeouts", n_to, 0);
      @(posedge clk);
      #1;
      check("run_ptype", param_type, 7);
      check("run_init", lstm_init, 0);

      lstm_done = 1'b1;
      for (int b = 1; b <= 8; b++) send_byte(8'(b));
      wait_en(1);
      check("x1_pulses", n_en, 1);
      check("x1_data", syscall_X_data, 64'h0102030405060708);
      check("x1_count", x_count, 1);

      for (int b = 8'h11; b <= 8'h18; b++) send_byte(8'(b));
      repeat (10) @(negedge clk);
      check("no_reissue", n_en, 1);
      check("full_ready", src_ready, 0);
      check("x1_stable", syscall_X_data, 64'h0102030405060708);
      @(posedge clk);
      #1 lstm_done = 1'b0;
      @(posedge clk);
      #1 lstm_done = 1'b1;
      wait_en(2);
      check("x2_pulses", n_en, 2);
      check("x2_data", syscall_X_data, 64'h1112131415161718);
      check("x2_count", x_count, 2);

      lstm_done = 1'b0;
      for (int b = 8'h21; b <= 8'h28; b++) send_byte(8'(b));
      src_data  = 8'h31;
      src_valid = 1'b1;
      rdy_hi = 0;
      repeat (20) begin
         @(negedge clk);
         if (src_ready) rdy_hi++;
      end
      check("bp_ready_low", rdy_hi, 0);
      check("bp_no_issue", n_en, 2);
      @(posedge clk);
      #1 lstm_done = 1'b1;
      send_byte(8'h31);
      wait_en(3);
      check("x3_data", syscall_X_data, 64'h2122232425262728);
      check("x3_pulses", n_en, 3);
      lstm_done = 1'b0;
      @(posedge clk);
      #1;
      for (int b = 8'h32; b <= 8'h38; b++) send_byte(8'(b));
      lstm_done = 1'b1;
      wait_en(4);
      check("x4_data", syscall_X_data, 64'h3132333435363738);
      check("x4_count", x_count, 4);
      check("run_timeouts", n_to, 0);

      pulse_start();
      repeat (3) @(negedge clk);
      check("run_start_ptype", param_type, 7);
      check("run_start_init", lstm_init, 0);
      check("run_start_ld", load_done, 1);

      @(posedge clk);
      #1 rst = 1'b1;
      #1;
      check("rrun_busy", busy, 0);
      check("rrun_ld", load_done, 0);
      check("rrun_xcount", x_count, 0);
      check("rrun_xdata", syscall_X_data, 0);
      check("rrun_enable", lstm_enable, 0);
      @(posedge clk);
      #1 rst = 1'b0;
      lstm_done = 1'b0;

      pat5a = 1'b1;
      mon_clear();
      @(posedge clk);
      #1 pulse_start();
      send_byte(8'h5A);
      @(negedge clk);
      check("chk_one", param_chksum, CHK_ONE_5A);
      for (int i = 1; i < 100; i++) send_byte(8'h5A);
      rst = 1'b1;
      #1;
      check("rload_busy", busy, 0);
      check("rload_ptype", param_type, 7);
      check("rload_init", lstm_init, 0);
      check("rload_ready", src_ready, 0);
      check("rload_chksum", param_chksum, 0);
      @(posedge clk);
      #1 rst = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      check("rload_need_start", busy, 0);

      mon_clear();
      @(posedge clk);
      #1 pulse_start();
      for (int i = 0; i < 560; i++) send_byte(8'h5A);
      wait_load_done();
      check("re_load_done", load_done, 1);
      check("re_n_w", n_t[0], 512);
      check("re_n_b", n_t[1], 32);
      check("re_n_c", n_t[2], 16);
      check("re_order", perr, 0);
      check("re_chksum", param_chksum, 0);
      check("re_timeouts", n_to, 0);

      $display("Simulation finished: %0d checks, %0d errors",
               n_checks, n_errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

endmodule
